// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states
// and the alignment rule used by both the stage and its lane logic.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } msize_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational lane steering: store data replication / byte enables, and
// load byte/half extraction with sign or zero extension.
module mem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  msize,
    input  logic        msext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wdata   = st_data;
        be      = 4'b1111;
        ld_data = ld_word;
        ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
        ld_half = ld_word[{addr_lo[1], 4'b0000} +: 16];
        case (msize)
            SZ_BYTE: begin
                wdata   = {4{st_data[7:0]}};
                be      = 4'b0001 << addr_lo;
                ld_data = {{24{msext & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                wdata   = {2{st_data[15:0]}};
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                ld_data = {{16{msext & ld_half[15]}}, ld_half};
            end
            default: begin
                wdata   = st_data;
                be      = 4'b1111;
                ld_data = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/pipemem.sv
// MEM stage: issues loads/stores over the req/ack data bus, stalls the
// upstream pipeline while a bus access is outstanding, flags faults.
module pipemem
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msext,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic        mwreg_out,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        merr,
    output logic        mberr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] mdata_q;
    logic        tflag_q;
    logic        req_q, we_q, mberr_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        access, aligned, start, fault_mis, fault;
    logic [31:0] lane_wdata, lane_ld;
    logic [3:0]  lane_be;

    assign access    = mm2reg | mwmem;
    assign aligned   = is_aligned(msize, malu[1:0]);
    assign start     = access & aligned;
    assign fault_mis = access & ~aligned;

    mem_lane u_lane (
        .msize   (msize),
        .msext   (msext),
        .addr_lo (malu[1:0]),
        .st_data (mb),
        .ld_word (mdata_q),
        .wdata   (lane_wdata),
        .be      (lane_be),
        .ld_data (lane_ld)
    );

    // Bus handshake: req rises with every bus field already valid and holds
    // them unchanged until the memory answers with a single-cycle ack; an ack
    // seen while req is low carries no meaning and is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            mdata_q <= 32'd0;
            tflag_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            mberr_q <= 1'b0;
        end else begin
            mberr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        cnt_q   <= 8'd0;
                        tflag_q <= 1'b0;
                        req_q   <= 1'b1;
                        we_q    <= mwmem;
                        addr_q  <= {malu[31:2], 2'b00};
                        be_q    <= lane_be;
                        wdata_q <= lane_wdata;
                    end
                end
                BUSY: begin
                    if (dmem_ack || cnt_q == CNT_LAST) begin
                        // Ack beats a timeout landing in the same cycle.
                        state_q <= DONE;
                        mdata_q <= dmem_ack ? dmem_rdata : 32'd0;
                        tflag_q <= ~dmem_ack;
                        mberr_q <= ~dmem_ack;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= 32'd0;
                        be_q    <= 4'd0;
                        wdata_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    tflag_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fault     = ((state_q == IDLE) & fault_mis) | ((state_q == DONE) & tflag_q);
    assign mstall    = ~reset & (((state_q == IDLE) & start) | (state_q == BUSY));
    assign merr      = ~reset & (state_q == IDLE) & fault_mis;
    assign mwreg_out = ~reset & mwreg & ~mstall & ~fault;
    assign mmo       = (~reset & (state_q == DONE) & mm2reg) ? lane_ld : 32'd0;
    assign mberr     = mberr_q;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipemem.sv
// Randomized scoreboard bench for pipemem: the driver predicts each
// instruction's result and bus transfer, monitors compare as they appear.
module tb_pipemem;

    localparam int TO = 4;

    logic        clock, reset;
    logic        mwreg, mm2reg, mwmem, msext;
    logic [1:0]  msize;
    logic [31:0] malu, mb;
    logic        mwreg_out, mstall, merr, mberr;
    logic [31:0] mmo;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [1:0]  dbg_state;

    pipemem #(.TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .msize      (msize),
        .msext      (msext),
        .malu       (malu),
        .mb         (mb),
        .mwreg_out  (mwreg_out),
        .mmo        (mmo),
        .mstall     (mstall),
        .merr       (merr),
        .mberr      (mberr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [42:0] exp_q[$];   // {latency[7:0], mwreg_out, merr, mberr, mmo}
    logic [68:0] bus_q[$];   // {we, be, addr, wdata}
    logic [35:0] plan_q[$];  // {ack delay in BUSY cycles, rdata}
    bit mon_en = 0, resp_en = 0, instr_valid = 0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_aligned(input int size, input int lo);
        return (size == 0) || (size == 1 && (lo % 2) == 0) || (size == 2 && lo == 0);
    endfunction

    function automatic logic [31:0] model_load(input int size, input bit sext, input int lo,
                                               input logic [31:0] rd);
        logic [31:0] v;
        if (size == 0) begin
            v = (rd >> (8 * lo)) & 32'hFF;
            if (sext && v >= 32'h80) v = v - 32'h100;
        end else if (size == 1) begin
            v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
            if (sext && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
        if (size == 0) return (d & 32'hFF) * 32'h01010101;
        if (size == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] model_be(input int size, input int lo);
        if (size == 0) return 4'(1 << lo);
        if (size == 1) return 4'(3 << (lo & 2));
        return 4'hF;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input bit wr, input bit ld, input bit st, input int size, input bit sext,
                         input logic [31:0] alu, input logic [31:0] d, input int delay,
                         input logic [31:0] rd);
        int lo, lat;
        bit mwo, me, mbe;
        logic [31:0] mo;
        mwreg = wr; mm2reg = ld; mwmem = st; msize = 2'(size); msext = sext; malu = alu; mb = d;
        lo = int'(alu[1:0]);
        mwo = wr; me = 0; mbe = 0; mo = 32'd0; lat = 1;
        if (ld || st) begin
            if (!model_aligned(size, lo)) begin
                mwo = 0; me = 1;
            end else begin
                bus_q.push_back({st, model_be(size, lo), alu & 32'hFFFF_FFFC, model_wdata(size, d)});
                plan_q.push_back({4'(delay), rd});
                if (delay <= TO - 1) begin
                    lat = delay + 3;
                    if (ld) mo = model_load(size, sext, lo, rd);
                end else begin
                    lat = TO + 2;
                    mwo = 0; mbe = 1;
                end
            end
        end
        exp_q.push_back({8'(lat), mwo, me, mbe, mo});
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!mstall) break;
            if (i == 39) begin
                n_vec++; n_err++;
                $display("FAIL stall_bound: got mstall still 1 after 40 cycles expected release");
            end
        end
        @(posedge clock); #1;
    endtask

    // ---------------- bus responder ----------------
    initial begin
        int idx;
        bit active;
        logic [35:0] p;
        idx = 0; active = 0; p = '0;
        forever begin
            @(posedge clock); #1;
            if (resp_en) begin
                if (dmem_req) begin
                    if (!active) begin
                        active = 1; idx = 0;
                        p = (plan_q.size() > 0) ? plan_q.pop_front() : {4'hF, 32'h0};
                    end else begin
                        idx++;
                    end
                    if (idx == int'(p[35:32])) begin
                        dmem_ack = 1'b1; dmem_rdata = p[31:0];
                    end else begin
                        dmem_ack = 1'b0; dmem_rdata = $urandom;
                    end
                end else begin
                    active = 0;
                    dmem_ack = ($urandom_range(0, 3) == 0);
                    dmem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin
        int lat;
        logic [42:0] e;
        lat = 0;
        forever begin
            @(negedge clock);
            if (mon_en && instr_valid) begin
                lat++;
                if (!mstall) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL result_unexpected: got completion expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 69'({8'(lat), mwreg_out, merr, mberr, mmo}), 69'(e));
                    end
                    lat = 0;
                end else begin
                    check("stall_outs", 69'({mwreg_out, merr, mberr}), 69'(0));
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (dmem_req) begin
                    if (bus_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL bus_unexpected: got req addr %h expected no request", dmem_addr);
                    end else begin
                        check("bus", {dmem_we, dmem_be, dmem_addr, dmem_wdata}, bus_q[0]);
                    end
                end else if (prev && bus_q.size() > 0) begin
                    void'(bus_q.pop_front());
                end
                prev = dmem_req;
            end else begin
                prev = 0;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int size, lo;
        logic [31:0] a;
        reset = 1; mwreg = 0; mm2reg = 0; mwmem = 0; msize = 0; msext = 0;
        malu = 0; mb = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ctl", 69'({mstall, merr, mberr, mwreg_out, dmem_req, dmem_we, dmem_be, dbg_state}), 69'(0));
        check("reset_data", 69'({mmo, dmem_addr}), 69'(0));
        check("reset_wdata", 69'(dmem_wdata), 69'(0));
        mm2reg = 1; msize = 2; mwreg = 1;
        @(posedge clock); @(negedge clock);
        check("reset_hold", 69'({mstall, dmem_req, mwreg_out, mmo}), 69'(0));

        @(posedge clock); #1;
        reset = 0; mm2reg = 0; mwreg = 0;
        mon_en = 1; resp_en = 1; instr_valid = 1;

        issue(1, 1, 0, 2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        issue(1, 1, 0, 0, 1, 32'h103, 32'h0, 1, 32'h80000000);
        issue(1, 1, 0, 0, 0, 32'h103, 32'h0, 0, 32'h80000000);
        issue(0, 0, 1, 1, 0, 32'h202, 32'h1234ABCD, 2, 32'h0BADF00D);
        issue(1, 1, 0, 2, 0, 32'h101, 32'h0, 0, 32'h0);
        issue(1, 1, 0, 2, 0, 32'h104, 32'h0, 7, 32'h55555555);
        issue(1, 1, 0, 2, 0, 32'h108, 32'h0, TO - 1, 32'h12345678);
        issue(1, 0, 0, 3, 0, 32'h111, 32'h0, 0, 32'h0);
        issue(1, 0, 1, 3, 0, 32'h110, 32'hFFFFFFFF, 0, 32'h0);
        issue(1, 1, 0, 1, 1, 32'h206, 32'h0, 1, 32'h8001_7FFF);

        for (int n = 0; n < 300; n++) begin
            int kind, s;
            kind = $urandom_range(0, 2);
            s = $urandom_range(0, 9);
            size = (s < 3) ? 0 : (s < 6) ? 1 : (s < 9) ? 2 : 3;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 1) a[0] = 1'b0;
                if (size == 2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), kind == 1, kind == 2, size, 1'($urandom_range(0, 1)),
                  a, $urandom, $urandom_range(0, 5), $urandom);
        end

        // Reset during the second BUSY cycle, with an ack arriving afterwards.
        instr_valid = 0; mon_en = 0; resp_en = 0; dmem_ack = 0;
        mwreg = 1; mm2reg = 1; mwmem = 0; msize = 2; malu = 32'h300;
        @(posedge clock); #1;
        check("rst_busy_req", 69'(dmem_req), 69'(1));
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0; mwreg = 0; mm2reg = 0; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        check("rst_after", 69'({dmem_req, mstall, dbg_state}), 69'(0));
        @(posedge clock); #1;
        dmem_ack = 0;
        @(negedge clock);
        check("rst_late_ack", 69'({dmem_req, mstall, mberr, merr, dbg_state, mmo}), 69'(0));

        @(posedge clock); #1;
        mon_en = 1; resp_en = 1; instr_valid = 1;
        issue(1, 1, 0, 1, 0, 32'h402, 32'h0, 0, 32'hA5A5_1234);
        instr_valid = 0;
        check("exp_left", 69'(exp_q.size()), 69'(0));
        check("bus_left", 69'(bus_q.size()), 69'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
